// File: rtl/uwire_pkg.sv
// rtl/uwire_pkg.sv - Shared types and Microwire frame constants for the EEPROM master
package uwire_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_ERASE = 3'd2,
        OP_EWEN  = 3'd3,
        OP_EWDS  = 3'd4,
        OP_ERAL  = 3'd5,
        OP_WRAL  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_OUT,
        ST_SHIFT_IN,
        ST_CS_GAP,
        ST_POLL,
        ST_DONE
    } state_e;

    localparam logic [1:0] UW_OPC_READ  = 2'b10;
    localparam logic [1:0] UW_OPC_WRITE = 2'b01;
    localparam logic [1:0] UW_OPC_ERASE = 2'b11;
    localparam logic [1:0] UW_OPC_EXT   = 2'b00;

    localparam logic [1:0] UW_PFX_EWEN = 2'b11;
    localparam logic [1:0] UW_PFX_EWDS = 2'b00;
    localparam logic [1:0] UW_PFX_ERAL = 2'b10;
    localparam logic [1:0] UW_PFX_WRAL = 2'b01;

    function automatic logic [1:0] uw_opcode(input op_e op);
        case (op)
            OP_READ:  return UW_OPC_READ;
            OP_WRITE: return UW_OPC_WRITE;
            OP_ERASE: return UW_OPC_ERASE;
            default:  return UW_OPC_EXT;
        endcase
    endfunction

    // Extended commands carry their sub-opcode in the top two address bits
    function automatic logic [1:0] uw_prefix(input op_e op);
        case (op)
            OP_EWEN: return UW_PFX_EWEN;
            OP_ERAL: return UW_PFX_ERAL;
            OP_WRAL: return UW_PFX_WRAL;
            default: return UW_PFX_EWDS;
        endcase
    endfunction

endpackage

// File: rtl/uwire_sk_gen.sv
// rtl/uwire_sk_gen.sv - SK divider with rise/fall strobes, enable and synchronous restart
module uwire_sk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic sk_rise,
    output logic sk_fall,
    output logic ee_sk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // Strobes lead the SK edge: they are high in the cycle before ee_sk toggles
    assign tick    = en && !restart && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sk_rise = tick && !ee_sk;
    assign sk_fall = tick && ee_sk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            ee_sk   <= 1'b0;
        end else if (!en || restart) begin
            div_cnt <= '0;
            ee_sk   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            ee_sk   <= ~ee_sk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uwire_eeprom_master.sv
// rtl/uwire_eeprom_master.sv - Microwire 93xx EEPROM master: framing, read capture, busy polling
module uwire_eeprom_master
    import uwire_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              ee_cs,
    output logic              ee_sk,
    output logic              ee_di,
    input  logic              ee_do
);

    localparam int NB_HDR = 3 + ADDR_W;
    localparam int NB_WR  = NB_HDR + DATA_W;
    localparam int SR_W   = NB_WR;
    localparam int BC_W   = $clog2(3 + ADDR_W + DATA_W + 1);
    localparam int WC_W   = $clog2(2 * CLK_DIV + 1);
    localparam int TC_W   = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] GAP_LD = WC_W'(2 * CLK_DIV - 1);

    state_e            state, state_n;
    op_e               op_q;
    logic [SR_W-1:0]   sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic [TC_W-1:0]   tmo_cnt;
    logic [DATA_W-1:0] rd_sr;
    logic              err_q, cs_q, di_q;
    logic              do_s1, do_s2;
    logic              fire, long_op, last_out, poll_tick, tmo_last;
    logic              sk_rise, sk_fall, sk_en;

    logic [1:0]        opc;
    logic [ADDR_W+1:0] pfx_ext;
    logic [ADDR_W-1:0] addr_field;
    logic [SR_W-1:0]   frame;

    assign fire      = cmd_valid && (state == ST_IDLE);
    assign long_op   = (op_q == OP_WRITE) || (op_q == OP_WRAL);
    assign last_out  = (bit_cnt == (long_op ? BC_W'(NB_WR) : BC_W'(NB_HDR)));
    assign poll_tick = (wait_cnt == '0);
    assign tmo_last  = (tmo_cnt == TC_W'(TIMEOUT - 1));
    assign sk_en     = (state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_DONE) && (wait_cnt == '0);
    assign rsp_err   = rsp_valid && err_q;
    assign ee_cs     = cs_q;
    assign ee_di     = di_q;

    always_comb begin
        opc        = uw_opcode(op_e'(cmd_op));
        pfx_ext    = {uw_prefix(op_e'(cmd_op)), {ADDR_W{1'b0}}};
        addr_field = (opc == UW_OPC_EXT) ? pfx_ext[ADDR_W+1:2] : cmd_addr;
        frame      = {1'b1, opc, addr_field, cmd_wdata};
    end

    uwire_sk_gen #(.CLK_DIV(CLK_DIV)) u_sk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sk_en),
        .restart (fire),
        .sk_rise (sk_rise),
        .sk_fall (sk_fall),
        .ee_sk   (ee_sk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:
                if (cmd_valid) state_n = (cmd_op == OP_RSVD) ? ST_DONE : ST_SHIFT_OUT;
            ST_SHIFT_OUT:
                if (sk_fall && last_out) begin
                    if (op_q == OP_READ)                           state_n = ST_SHIFT_IN;
                    else if (op_q == OP_EWEN || op_q == OP_EWDS)   state_n = ST_DONE;
                    else                                           state_n = ST_CS_GAP;
                end
            ST_SHIFT_IN:
                if (sk_fall && bit_cnt == BC_W'(DATA_W + 1)) state_n = ST_DONE;
            ST_CS_GAP:
                if (poll_tick) state_n = ST_POLL;
            ST_POLL:
                if (poll_tick && (do_s2 || tmo_last)) state_n = ST_DONE;
            ST_DONE:
                if (wait_cnt == '0) state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_s1 <= 1'b0;
            do_s2 <= 1'b0;
        end else begin
            do_s1 <= ee_do;
            do_s2 <= do_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_READ;
            sr        <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            tmo_cnt   <= '0;
            rd_sr     <= '0;
            rsp_rdata <= '0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            di_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (fire) begin
                        op_q    <= op_e'(cmd_op);
                        sr      <= frame;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        if (cmd_op == OP_RSVD) begin
                            err_q    <= 1'b1;
                            wait_cnt <= WC_W'(2);
                        end else begin
                            err_q <= 1'b0;
                            cs_q  <= 1'b1;
                            di_q  <= 1'b1;
                        end
                    end
                ST_SHIFT_OUT: begin
                    if (sk_rise) bit_cnt <= bit_cnt + 1'b1;
                    if (sk_fall) begin
                        if (last_out) begin
                            di_q    <= 1'b0;
                            bit_cnt <= '0;
                            if (op_q != OP_READ) begin
                                cs_q     <= 1'b0;
                                wait_cnt <= GAP_LD;
                            end
                        end else begin
                            sr   <= sr << 1;
                            di_q <= sr[SR_W-2];
                        end
                    end
                end
                ST_SHIFT_IN: begin
                    // The first rise after the address clocks the dummy 0 and is skipped
                    if (sk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt != '0) rd_sr <= {rd_sr[DATA_W-2:0], do_s2};
                    end
                    if (sk_fall && bit_cnt == BC_W'(DATA_W + 1)) begin
                        cs_q     <= 1'b0;
                        wait_cnt <= GAP_LD;
                    end
                end
                ST_CS_GAP:
                    if (poll_tick) begin
                        cs_q     <= 1'b1;
                        wait_cnt <= GAP_LD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                ST_POLL:
                    if (poll_tick) begin
                        wait_cnt <= GAP_LD;
                        if (do_s2) begin
                            cs_q <= 1'b0;
                        end else if (tmo_last) begin
                            cs_q  <= 1'b0;
                            err_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                ST_DONE: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    // Read data changes on the same edge that raises rsp_valid
                    if (wait_cnt == WC_W'(1) && op_q == OP_READ && !err_q) rsp_rdata <= rd_sr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uwire_eeprom_master.sv
// tb/tb_uwire_eeprom_master.sv - Directed bench for uwire_eeprom_master with a 93C46 x16 pin model
module tb_uwire_eeprom_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        ee_cs, ee_sk, ee_di;
    logic        ee_do;

    int total = 0;
    int bad   = 0;

    int          r_got, r_rise, r_first, r_gap, r_poll, r_done, r_badsk, r_baddi, r_aborted;
    logic [31:0] r_di;
    logic [15:0] r_rdata;
    logic        r_err, r_cs;
    logic        seen_act, seen_busy, seen_rsp;

    uwire_eeprom_master #(
        .ADDR_W  (6),
        .DATA_W  (16),
        .CLK_DIV (2),
        .TIMEOUT (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ee_cs     (ee_cs),
        .ee_sk     (ee_sk),
        .ee_di     (ee_di),
        .ee_do     (ee_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and plays the EEPROM side until rsp_valid, a budget expiry or the abort rise
    task automatic run_cmd(input logic [2:0] op, input logic [5:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd_word, input int ready_delay, input int abort_at);
        int   fall_cyc, n_fall;
        logic psk, pcs, pdi;
        r_got = 0; r_rise = 0; r_first = -1; r_gap = -1; r_poll = -1; r_done = -1;
        r_badsk = 0; r_baddi = 0; r_aborted = 0; r_di = '0; r_rdata = '0; r_err = 1'b0; r_cs = 1'b1;
        n_fall = 0; fall_cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; ee_do = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        psk = 1'b0; pcs = 1'b0; pdi = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ee_cs && ee_sk) r_badsk++;
            if (ee_sk && ee_di !== pdi) r_baddi++;
            if (ee_sk && !psk) begin
                r_rise++;
                r_di = {r_di[30:0], ee_di};
                if (r_rise == 1) r_first = cyc;
                if (r_rise == 9) ee_do = 1'b0;
                else if (r_rise >= 10 && r_rise <= 25) ee_do = rd_word[25 - r_rise];
                if (r_rise == abort_at) begin
                    rst_n = 1'b0;
                    r_aborted = 1;
                    break;
                end
            end
            if (pcs && !ee_cs) begin n_fall++; fall_cyc = cyc; end
            if (!pcs && ee_cs && n_fall > 0 && r_gap < 0) begin r_gap = cyc - fall_cyc; r_poll = cyc; end
            if (r_poll >= 0 && ee_cs) ee_do = ((cyc - r_poll) >= ready_delay);
            if (rsp_valid) begin
                r_got = 1; r_done = cyc; r_rdata = rsp_rdata; r_err = rsp_err; r_cs = ee_cs;
                break;
            end
            psk = ee_sk; pcs = ee_cs; pdi = ee_di;
            @(negedge clk);
        end
        ee_do = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_wdata = '0; ee_do = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_pins", {ee_cs, ee_sk, ee_di}, 0);
        chk("reset_rsp", {rsp_valid, rsp_err, busy}, 0);
        chk("reset_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(3'd3, 6'h00, 16'h0000, 16'h0000, 0, 0);
        chk("ewen_done", r_got, 1);
        chk("ewen_rises", r_rise, 9);
        chk("ewen_di", r_di, 32'h130);
        chk("ewen_first_rise", r_first, 2);
        chk("ewen_cs", r_cs, 0);
        chk("ewen_err", r_err, 0);
        chk("ewen_sk_hyg", r_badsk, 0);
        chk("ewen_di_hyg", r_baddi, 0);

        run_cmd(3'd0, 6'h15, 16'h0000, 16'hA5C3, 0, 0);
        chk("read_done", r_got, 1);
        chk("read_rises", r_rise, 26);
        chk("read_hdr", r_di >> 17, 32'h195);
        chk("read_di_tail", r_di[16:0], 0);
        chk("read_data", r_rdata, 16'hA5C3);
        chk("read_err", r_err, 0);
        chk("read_cs", r_cs, 0);
        chk("read_di_hyg", r_baddi, 0);

        run_cmd(3'd1, 6'h3F, 16'h1234, 16'h0000, 200, 0);
        chk("write_done", r_got, 1);
        chk("write_rises", r_rise, 25);
        chk("write_di", r_di, 32'h17F1234);
        chk("write_gap", r_gap, 4);
        chk("write_poll_lo", (r_done - r_poll) >= 200, 1);
        chk("write_poll_hi", (r_done - r_poll) <= 212, 1);
        chk("write_err", r_err, 0);
        chk("write_cs", r_cs, 0);
        chk("write_sk_hyg", r_badsk, 0);

        run_cmd(3'd2, 6'h2A, 16'h0000, 16'h0000, 1000000, 0);
        chk("erase_done", r_got, 1);
        chk("erase_di", r_di, 32'h1EA);
        chk("erase_gap", r_gap, 4);
        chk("erase_tmo_lo", (r_done - r_poll) >= 400, 1);
        chk("erase_tmo_hi", (r_done - r_poll) <= 408, 1);
        chk("erase_err", r_err, 1);
        chk("erase_cs", r_cs, 0);

        seen_act = 1'b0; seen_busy = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_addr = 6'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd0;
        seen_act |= ee_cs | ee_sk | ee_di;
        chk("rsv_busy", busy, 1);
        chk("rsv_c1", rsp_valid, 0);
        @(negedge clk);
        seen_act |= ee_cs | ee_sk | ee_di;
        chk("rsv_c2", rsp_valid, 0);
        @(negedge clk);
        seen_act |= ee_cs | ee_sk | ee_di;
        chk("rsv_valid", rsp_valid, 1);
        chk("rsv_err", rsp_err, 1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_act  |= ee_cs | ee_sk | ee_di;
            seen_busy |= busy;
        end
        chk("rsv_no_pins", seen_act, 0);
        chk("rsv_not_queued", seen_busy, 0);
        chk("rsv_ready", cmd_ready, 1);

        run_cmd(3'd0, 6'h15, 16'h0000, 16'hA5C3, 0, 12);
        #1;
        chk("abort_hit", r_aborted, 1);
        chk("abort_pins", {ee_cs, ee_sk, ee_di}, 0);
        chk("abort_rsp", {busy, rsp_valid, rsp_err}, 0);
        chk("abort_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_rsp |= rsp_valid;
        end
        chk("abort_no_rsp", seen_rsp, 0);
        chk("abort_ready", cmd_ready, 1);

        run_cmd(3'd0, 6'h0A, 16'h0000, 16'h5A3C, 0, 0);
        chk("read2_done", r_got, 1);
        chk("read2_rises", r_rise, 26);
        chk("read2_hdr", r_di >> 17, 32'h18A);
        chk("read2_data", r_rdata, 16'h5A3C);
        chk("read2_err", r_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
